// File: rtl/pn_edge_gen.sv
// pn_edge_gen -- transmit-side edge generator.
//
// Rising (P) and falling (N) edge requests are queued and replayed onto the
// level output Cout.  Cout holds each level for at least HOLD_CYC cycles, so
// a pos/neg edge detector on Cout regenerates the requested pulse sequence.
//
// Parameters:
//   HOLD_CYC  minimum cycles Cout holds a level after an edge (1..255)
//   DEPTH     request queue entries (power of 2, >= 2)
//
// Ports:
//   Clk   in   clock, rising edge active
//   Rst   in   asynchronous active-high reset
//   P     in   rising-edge request strobe
//   N     in   falling-edge request strobe
//   Cout  out  generated level (registered)
//   Busy  out  holding a level or queue non-empty (registered)
//   Full  out  queue holds DEPTH entries (registered)
//   Err   out  sticky: some request was dropped; cleared only by Rst
//   Pe    out  one-cycle strobe aligned with a 0->1 on Cout   (PN_ECHO_EN)
//   Ne    out  one-cycle strobe aligned with a 1->0 on Cout   (PN_ECHO_EN)
//
// Build option: define PN_ECHO_EN to add the Pe/Ne echo outputs.

module pn_edge_gen #(
   parameter int unsigned HOLD_CYC = 4,
   parameter int unsigned DEPTH    = 4
) (
   input  logic Clk,
   input  logic Rst,
   input  logic P,
   input  logic N,
   output logic Cout,
   output logic Busy,
   output logic Full,
`ifdef PN_ECHO_EN
   output logic Err,
   output logic Pe,
   output logic Ne
`else
   output logic Err
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [7:0]  HOLD_M1  = 8'(HOLD_CYC - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state_q, state_d;
   logic [7:0]       hcnt_q, hcnt_d;
   logic [DEPTH-1:0] mem_q;            // 1 = rise entry, 0 = fall entry
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             lp_q, lp_d;       // level after all queued edges
   logic             cout_q, cout_d;
   logic             err_q, err_d;
   logic             busy_q, full_q;

   logic head, pop, room, push_p, push_n, push, drop;

   always_comb begin
      head   = mem_q[rd_q];
      // The pop decision uses only registered state, so an entry pushed this
      // edge is never popped at the same edge.
      pop    = (cnt_q != '0) && ((state_q == IDLE) || (hcnt_q == 8'd0));
      // A simultaneous pop frees the slot a full queue would otherwise lack.
      room   = (cnt_q != DEPTH_C) || pop;
      push_p = P && !N && !lp_q && room;
      push_n = N && !P &&  lp_q && room;
      push   = push_p || push_n;
      // Anything requested but not pushed is a drop: both strobes, a
      // redundant edge, or no room.
      drop   = (P || N) && !push;

      state_d = state_q;
      hcnt_d  = hcnt_q;
      cout_d  = cout_q;
      if (pop) begin
         cout_d  = head;
         hcnt_d  = HOLD_M1;
         state_d = HOLD;
      end else if (state_q == HOLD) begin
         if (hcnt_q != 8'd0) hcnt_d = hcnt_q - 8'd1;
         else                state_d = IDLE;
      end

      wr_d  = push ? wr_q + AW'(1) : wr_q;
      rd_d  = pop  ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      lp_d  = push ? push_p : lp_q;
      err_d = err_q || drop;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         hcnt_q  <= 8'd0;
         mem_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         lp_q    <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         if (push) mem_q[wr_q] <= push_p;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         lp_q    <= lp_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         busy_q  <= (state_d == HOLD) || (cnt_d != '0);
         full_q  <= (cnt_d == DEPTH_C);
      end
   end

   assign Cout = cout_q;
   assign Busy = busy_q;
   assign Full = full_q;
   assign Err  = err_q;

`ifdef PN_ECHO_EN
   logic pe_q, ne_q;

   // Queue entries alternate, so every pop is a real transition of Cout.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         pe_q <= 1'b0;
         ne_q <= 1'b0;
      end else begin
         pe_q <= pop &&  head;
         ne_q <= pop && !head;
      end
   end

   assign Pe = pe_q;
   assign Ne = ne_q;
`endif

endmodule

// File: tb/tb_pn_edge_gen.sv
// Bench for pn_edge_gen (HOLD_CYC=4, DEPTH=4).  Expected Cout edges are
// queued when a stimulus sequence is launched and consumed as Cout moves.

module tb_pn_edge_gen;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   logic P   = 1'b0;
   logic N   = 1'b0;
   logic Cout, Busy, Full, Err;
`ifdef PN_ECHO_EN
   logic Pe, Ne;
`endif

   pn_edge_gen #(.HOLD_CYC(4), .DEPTH(4)) dut (
      .Clk  (Clk),
      .Rst  (Rst),
      .P    (P),
      .N    (N),
      .Cout (Cout),
      .Busy (Busy),
      .Full (Full),
`ifdef PN_ECHO_EN
      .Err  (Err),
      .Pe   (Pe),
      .Ne   (Ne)
`else
      .Err  (Err)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct { int e; int lvl; } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   int cout_h[64], busy_h[64], full_h[64], err_h[64], pe_h[64], ne_h[64];

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic exp_edge(input int e, input int lvl);
      exp_t x;
      x.e = e; x.lvl = lvl;
      sb.push_back(x);
   endtask

   task automatic do_reset();
      Rst = 1'b1; P = 1'b0; N = 1'b0;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
   endtask

   // Bit e of pm/nm drives P/N into edge e; edge 1 is the first edge run.
   task automatic run_seq(input logic [63:0] pm, input logic [63:0] nm, input int n);
      int prev;
      exp_t x;
      prev = Cout;
      for (int e = 1; e <= n; e++) begin
         P = pm[e]; N = nm[e];
         @(posedge Clk);
         #1;
         P = 1'b0; N = 1'b0;
         cout_h[e] = Cout; busy_h[e] = Busy; full_h[e] = Full; err_h[e] = Err;
`ifdef PN_ECHO_EN
         pe_h[e] = Pe; ne_h[e] = Ne;
`else
         pe_h[e] = 0; ne_h[e] = 0;
`endif
         if (int'(Cout) != prev) begin
            if (sb.size() == 0) chk("edge_spurious", e, -1);
            else begin
               x = sb.pop_front();
               chk("edge_at", e, x.e);
               chk("edge_lvl", Cout, x.lvl);
            end
         end
         prev = Cout;
      end
      chk("edges_missing", sb.size(), 0);
      sb.delete();
   endtask

   function automatic logic [63:0] bits(input int a, input int b = 0,
                                        input int c = 0, input int d = 0);
      logic [63:0] v;
      v = '0;
      if (a > 0) v[a] = 1'b1;
      if (b > 0) v[b] = 1'b1;
      if (c > 0) v[c] = 1'b1;
      if (d > 0) v[d] = 1'b1;
      return v;
   endfunction

   initial begin
      // reset state
      do_reset();
      chk("rst_cout", Cout, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_full", Full, 0);
      chk("rst_err",  Err,  0);

      // single rise
      exp_edge(11, 1);
      run_seq(bits(10), '0, 20);
      chk("basic_cout11", cout_h[11], 1);
      for (int e = 11; e <= 14; e++) chk("basic_busy_hi", busy_h[e], 1);
      chk("basic_busy15", busy_h[15], 0);
      chk("basic_err", err_h[20], 0);

      // queued pair
      do_reset();
      exp_edge(11, 1); exp_edge(15, 0);
      run_seq(bits(10), bits(11), 24);
      chk("pair_busy18", busy_h[18], 1);
      chk("pair_busy19", busy_h[19], 0);
      chk("pair_err", err_h[24], 0);

      // queue fills, all six accepted
      do_reset();
      exp_edge(11, 1); exp_edge(15, 0); exp_edge(19, 1);
      exp_edge(23, 0); exp_edge(27, 1); exp_edge(31, 0);
      run_seq(bits(10, 12, 14), bits(11, 13, 15), 36);
      chk("full_13", full_h[13], 0);
      chk("full_14", full_h[14], 1);
      chk("full_15", full_h[15], 1);
      chk("full_err", err_h[36], 0);
      chk("full_busy", busy_h[36], 0);

      // extra request while full with no pop is dropped
      do_reset();
      exp_edge(11, 1); exp_edge(15, 0); exp_edge(19, 1);
      exp_edge(23, 0); exp_edge(27, 1); exp_edge(31, 0);
      run_seq(bits(10, 12, 14, 16), bits(11, 13, 15), 36);
      chk("ovf_err15", err_h[15], 0);
      chk("ovf_err16", err_h[16], 1);

      // P and N together
      do_reset();
      run_seq(bits(10), bits(10), 20);
      chk("pn_err9", err_h[9], 0);
      chk("pn_err10", err_h[10], 1);
      chk("pn_cout", cout_h[20], 0);

      // redundant fall
      do_reset();
      run_seq('0, bits(10), 20);
      chk("red_err", err_h[10], 1);
      chk("red_cout", cout_h[20], 0);

      // async reset while holding with two entries queued
      do_reset();
      exp_edge(11, 1);
      run_seq(bits(10, 12), bits(11), 12);
      chk("mid_full_pre", Busy, 1);
      #2 Rst = 1'b1;
      #1;
      chk("mid_cout", Cout, 0);
      chk("mid_busy", Busy, 0);
      chk("mid_full", Full, 0);
      chk("mid_err",  Err,  0);
      #2 Rst = 1'b0;
      run_seq('0, '0, 20);
      exp_edge(11, 1);
      run_seq(bits(10), '0, 16);

`ifdef PN_ECHO_EN
      do_reset();
      exp_edge(11, 1); exp_edge(15, 0);
      run_seq(bits(10), bits(12), 20);
      chk("pe10", pe_h[10], 0);
      chk("pe11", pe_h[11], 1);
      chk("pe12", pe_h[12], 0);
      chk("ne14", ne_h[14], 0);
      chk("ne15", ne_h[15], 1);
      chk("ne16", ne_h[16], 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pn_edge_gen.md
Name: pn_edge_gen

Overview:
- Transmit-side counterpart of the pos/neg edge detector.
- Accepts single-cycle rising-edge requests (P) and falling-edge requests (N), queues them, and drives them onto a level output Cout.
- Enforces a minimum level hold time between successive edges.
- A detector on Cout regenerates the same P/N pulse sequence, spaced by at least HOLD_CYC cycles.

Parameters:
- HOLD_CYC, 4: minimum cycles Cout holds its level after any edge; legal range 1..255.
- DEPTH, 4: request queue entries; power of 2, at least 2.

Ports:
- Clk  in  1: clock, rising-edge active.
- Rst  in  1: asynchronous, active-high reset.
- P  in  1: request a rising edge on Cout; one-cycle strobe.
- N  in  1: request a falling edge on Cout; one-cycle strobe.
- Cout  out  1: generated level, registered.
- Busy  out  1: high when in HOLD or the queue is non-empty.
- Full  out  1: high when the queue holds DEPTH entries.
- Err  out  1: sticky flag for any dropped request; cleared only by Rst.
- Pe  out  1: rising-edge echo strobe; present only with PN_ECHO_EN.
- Ne  out  1: falling-edge echo strobe; present only with PN_ECHO_EN.

Behaviour:
- Reset (async, Rst=1):
  - Cout=0, Err=0, queue empty, Full=0, Busy=0.
  - State IDLE, hold counter 0, projected level Lp=0, Pe=Ne=0.
- Lp is the level Cout will have after all queued edges are applied.
  - Updated on every accepted push.
- Push rules, evaluated each rising Clk edge:
  - P=1, N=0: accept if Lp=0 and there is room; pushes a rise entry; Lp<=1.
  - N=1, P=0: accept if Lp=1 and there is room; pushes a fall entry; Lp<=0.
  - P=1 and N=1: drop both; Err<=1.
  - Redundant request (P with Lp=1, or N with Lp=0): drop; Err<=1.
  - Full at the same edge as a pop: accept, since the pop frees the slot.
  - Full with no pop: drop; Err<=1.
- FSM:
  - IDLE:
    - Queue non-empty: pop the head, Cout<=head type, counter<=HOLD_CYC-1, go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD, counter > 0: counter decrements each cycle.
  - HOLD, counter = 0, queue non-empty: pop, apply to Cout, reload counter to HOLD_CYC-1, stay in HOLD.
  - HOLD, counter = 0, queue empty: go to IDLE.
  - With HOLD_CYC=1, back-to-back queued edges are applied on consecutive cycles.
- Latency:
  - Request sampled at edge k with queue empty and state IDLE: entry is visible after edge k, and Cout changes at edge k+1.
  - Successive applied edges are exactly HOLD_CYC cycles apart while the queue stays non-empty.
  - A request pushed into an empty queue at the edge where counter=0 in HOLD is not popped at that edge. FSM goes to IDLE; the entry is applied at the next edge.
- Pointer arithmetic:
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter is log2(DEPTH)+1 bits.
  - Full = (count==DEPTH).
- Queue entries always alternate in type, because redundant requests are rejected.
- Busy, Full and Err are registered; no combinational path from P or N to any output.
- Rst mid-operation: immediate return to reset values; queued entries are discarded.

Optional Feature:
- Macro: PN_ECHO_EN.
- Defined:
  - Pe=1 for exactly one cycle in the same cycle Cout goes 0->1.
  - Ne=1 likewise for 1->0.
  - Both are registered with Cout, so they are cycle-aligned with the edge.
- Undefined: Pe and Ne ports do not exist; no echo logic is built.

Test Plan:
- Basic edges, reset then P at edge 10:
  - Cout=1 from edge 11; Busy high from edge 11 through edge 14, low from edge 15; Err=0.
- Queued pair, P at edge 10, N at edge 11:
  - Cout rises at edge 11 and falls at edge 15; Busy low from edge 19.
- Queue full, HOLD_CYC=4, DEPTH=4, alternating P/N on edges 10..15:
  - Pops at edges 11 and 15 free slots, so all six requests are accepted.
  - Full=1 after edge 14.
  - Cout toggles at edges 11, 15, 19, 23, 27, 31.
  - Repeat with an additional request at edge 16: it is dropped and Err=1.
- Illegal requests:
  - P and N together at edge 10: no Cout change; Err=1.
  - Reset, then N at edge 10 while Lp=0: dropped; Err=1; Cout stays 0.
- Async reset mid-HOLD: assert Rst between edges with 2 entries queued.
  - Cout, Busy, Full and Err all go to 0 immediately.
  - No edge occurs after Rst is released until a new P.
- Echo (PN_ECHO_EN defined), P at edge 10 then N at edge 12:
  - Pe pulses in the cycle after edge 11; Ne pulses in the cycle after edge 15.
  - Each pulse lasts exactly one cycle.
